// File: rtl/sysbus_pkg.sv
// Shared types and tag-field constants for the Sysbus master-port arbiter.
package sysbus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RDATA,
        WDATA
    } arb_state_t;

    // Read/write flag position in the default 13-bit Sysbus tag.
    localparam int SYSBUS_RW_BIT = 12;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the master that did not win last time gets it.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       grant
);

    always_comb begin
        valid = |req;
        grant = (req == 2'b11) ? ~last_grant : req[1];
    end

endmodule

// File: rtl/sysbus_arbiter.sv
// Shares the Sysbus master port between the I-cache (m0) and D-cache (m1);
// the grant is held for the address phase plus BEATS data beats.
module sysbus_arbiter
    import sysbus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m0_bus_reqcyc,
    input  logic                      m1_bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m0_bus_req,
    input  logic [BUS_DATA_WIDTH-1:0] m1_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m0_bus_reqtag,
    input  logic [BUS_TAG_WIDTH-1:0]  m1_bus_reqtag,
    input  logic                      m0_bus_respack,
    input  logic                      m1_bus_respack,
    output logic                      m0_bus_reqack,
    output logic                      m1_bus_reqack,
    output logic                      m0_bus_respcyc,
    output logic                      m1_bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] m0_bus_resp,
    output logic [BUS_DATA_WIDTH-1:0] m1_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  m0_bus_resptag,
    output logic [BUS_TAG_WIDTH-1:0]  m1_bus_resptag,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respack,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      busy,
    output logic                      grant
);

    localparam int RW_BIT = BUS_TAG_WIDTH - 1;
    localparam int CNT_W  = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_t          state, next_state;
    logic                grant_q, last_grant_q;
    logic [CNT_W-1:0]    beat_cnt, beat_cnt_d;
    logic                arb_valid, arb_grant;

    logic                      sel_reqcyc, sel_respack;
    logic [BUS_DATA_WIDTH-1:0] sel_req;
    logic [BUS_TAG_WIDTH-1:0]  sel_reqtag;

    rr_arbiter2 u_rr (
        .req        ({m1_bus_reqcyc, m0_bus_reqcyc}),
        .last_grant (last_grant_q),
        .valid      (arb_valid),
        .grant      (arb_grant)
    );

    always_comb begin
        sel_reqcyc  = grant_q ? m1_bus_reqcyc  : m0_bus_reqcyc;
        sel_req     = grant_q ? m1_bus_req     : m0_bus_req;
        sel_reqtag  = grant_q ? m1_bus_reqtag  : m0_bus_reqtag;
        sel_respack = grant_q ? m1_bus_respack : m0_bus_respack;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt     <= '0;
        end else begin
            state    <= next_state;
            beat_cnt <= beat_cnt_d;
            if (state == IDLE && arb_valid) begin
                grant_q      <= arb_grant;
                last_grant_q <= arb_grant;
            end
        end
    end

    // Outputs are forced low while reset is high so a mid-transaction reset
    // silences the port in the same cycle rather than one edge later.
    always_comb begin
        next_state     = state;
        beat_cnt_d     = beat_cnt;
        bus_reqcyc     = 1'b0;
        bus_req        = '0;
        bus_reqtag     = '0;
        bus_respack    = 1'b0;
        m0_bus_reqack  = 1'b0;
        m1_bus_reqack  = 1'b0;
        m0_bus_respcyc = 1'b0;
        m1_bus_respcyc = 1'b0;
        m0_bus_resp    = '0;
        m1_bus_resp    = '0;
        m0_bus_resptag = '0;
        m1_bus_resptag = '0;
        busy           = 1'b0;
        grant          = 1'b0;
        if (!reset) begin
            busy  = (state != IDLE);
            grant = grant_q;
            case (state)
                IDLE: begin
                    if (arb_valid)
                        next_state = ADDR;
                end
                ADDR: begin
                    bus_reqcyc    = sel_reqcyc;
                    bus_req       = sel_req;
                    bus_reqtag    = sel_reqtag;
                    m0_bus_reqack = ~grant_q & bus_reqack;
                    m1_bus_reqack = grant_q & bus_reqack;
                    if (!sel_reqcyc) begin
                        next_state = IDLE;
                    end else if (bus_reqack) begin
                        next_state = sel_reqtag[RW_BIT] ? RDATA : WDATA;
                        beat_cnt_d = '0;
                    end
                end
                RDATA: begin
                    m0_bus_respcyc = ~grant_q & bus_respcyc;
                    m1_bus_respcyc = grant_q & bus_respcyc;
                    m0_bus_resp    = bus_resp;
                    m1_bus_resp    = bus_resp;
                    m0_bus_resptag = bus_resptag;
                    m1_bus_resptag = bus_resptag;
                    bus_respack    = sel_respack;
                    if (bus_respcyc && sel_respack) begin
                        beat_cnt_d = beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_BEAT)
                            next_state = IDLE;
                    end
                end
                WDATA: begin
                    bus_reqcyc    = sel_reqcyc;
                    bus_req       = sel_req;
                    bus_reqtag    = sel_reqtag;
                    m0_bus_reqack = ~grant_q & bus_reqack;
                    m1_bus_reqack = grant_q & bus_reqack;
                    if (sel_reqcyc && bus_reqack) begin
                        beat_cnt_d = beat_cnt + CNT_W'(1);
                        if (beat_cnt == LAST_BEAT)
                            next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: reads, writes with stalls, fairness, reset and abort.
module tb_sysbus_arbiter;
    import sysbus_pkg::*;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int BEATS = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_bus_reqcyc, m1_bus_reqcyc;
    logic [DW-1:0] m0_bus_req, m1_bus_req;
    logic [TW-1:0] m0_bus_reqtag, m1_bus_reqtag;
    logic          m0_bus_respack, m1_bus_respack;
    logic          m0_bus_reqack, m1_bus_reqack;
    logic          m0_bus_respcyc, m1_bus_respcyc;
    logic [DW-1:0] m0_bus_resp, m1_bus_resp;
    logic [TW-1:0] m0_bus_resptag, m1_bus_resptag;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_respack;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          busy, grant;

    logic [1:0]    reqack_v, respcyc_v;
    logic          any_out;
    logic [TW-1:0] rd_tag, wr_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sysbus_arbiter #(
        .BUS_DATA_WIDTH (DW),
        .BUS_TAG_WIDTH  (TW),
        .BEATS          (BEATS)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .m0_bus_reqcyc  (m0_bus_reqcyc),
        .m1_bus_reqcyc  (m1_bus_reqcyc),
        .m0_bus_req     (m0_bus_req),
        .m1_bus_req     (m1_bus_req),
        .m0_bus_reqtag  (m0_bus_reqtag),
        .m1_bus_reqtag  (m1_bus_reqtag),
        .m0_bus_respack (m0_bus_respack),
        .m1_bus_respack (m1_bus_respack),
        .m0_bus_reqack  (m0_bus_reqack),
        .m1_bus_reqack  (m1_bus_reqack),
        .m0_bus_respcyc (m0_bus_respcyc),
        .m1_bus_respcyc (m1_bus_respcyc),
        .m0_bus_resp    (m0_bus_resp),
        .m1_bus_resp    (m1_bus_resp),
        .m0_bus_resptag (m0_bus_resptag),
        .m1_bus_resptag (m1_bus_resptag),
        .bus_reqcyc     (bus_reqcyc),
        .bus_req        (bus_req),
        .bus_reqtag     (bus_reqtag),
        .bus_respack    (bus_respack),
        .bus_reqack     (bus_reqack),
        .bus_respcyc    (bus_respcyc),
        .bus_resp       (bus_resp),
        .bus_resptag    (bus_resptag),
        .busy           (busy),
        .grant          (grant)
    );

    assign reqack_v  = {m1_bus_reqack, m0_bus_reqack};
    assign respcyc_v = {m1_bus_respcyc, m0_bus_respcyc};
    assign any_out   = |{m0_bus_reqack, m1_bus_reqack, m0_bus_respcyc, m1_bus_respcyc,
                         m0_bus_resp, m1_bus_resp, m0_bus_resptag, m1_bus_resptag,
                         bus_reqcyc, bus_req, bus_reqtag, bus_respack, busy, grant};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit m, input logic cyc, input logic [DW-1:0] d,
                           input logic [TW-1:0] t);
        if (m) begin
            m1_bus_reqcyc = cyc; m1_bus_req = d; m1_bus_reqtag = t;
        end else begin
            m0_bus_reqcyc = cyc; m0_bus_req = d; m0_bus_reqtag = t;
        end
    endtask

    // Entered and left at a drive slot (just after a rising edge).
    task automatic do_reset();
        reset = 1'b1;
        m0_bus_reqcyc = 1'b0;
        m1_bus_reqcyc = 1'b0;
        bus_reqack = 1'b0;
        @(negedge clk);
        chk("rst_outs", 64'(any_out), 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_outs", 64'(any_out), 64'd0);
        tick();
    endtask

    // Entered in an IDLE cycle at its drive slot; on a full transaction it
    // returns at the drive slot of the IDLE cycle that follows the last beat.
    task automatic read_txn(input bit m, input logic [DW-1:0] addr,
                            input logic [DW-1:0] dbase, input int nbeats);
        set_req(m, 1'b1, addr, rd_tag);
        m0_bus_respack = ~m;
        m1_bus_respack = m;
        @(negedge clk);
        chk("arb_idle_busy", 64'(busy), 64'd0);
        chk("arb_idle_reqcyc", 64'(bus_reqcyc), 64'd0);
        tick();
        bus_reqack = 1'b1;
        @(negedge clk);
        chk("addr_grant", 64'(grant), 64'(m));
        chk("addr_reqcyc", 64'(bus_reqcyc), 64'd1);
        chk("addr_req", bus_req, addr);
        chk("addr_tag", 64'(bus_reqtag), 64'(rd_tag));
        chk("addr_reqack", 64'(reqack_v), m ? 64'd2 : 64'd1);
        tick();
        bus_reqack = 1'b0;
        set_req(m, 1'b0, addr, rd_tag);
        for (int i = 0; i < nbeats; i++) begin
            bus_respcyc = 1'b1;
            bus_resp    = dbase + 64'(i);
            bus_resptag = rd_tag;
            @(negedge clk);
            chk("rd_respcyc", 64'(respcyc_v), m ? 64'd2 : 64'd1);
            chk("rd_resp", m ? m1_bus_resp : m0_bus_resp, dbase + 64'(i));
            chk("rd_respack", 64'(bus_respack), 64'd1);
            chk("rd_busy", 64'(busy), 64'd1);
            tick();
        end
        if (nbeats == BEATS)
            bus_respcyc = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rd_tag = {1'b0, 4'h1, 8'h00};
        rd_tag[SYSBUS_RW_BIT] = 1'b1;
        wr_tag = {1'b0, 4'h1, 8'h00};
        reset = 1'b1;
        m0_bus_reqcyc = 1'b0; m0_bus_req = '0; m0_bus_reqtag = '0; m0_bus_respack = 1'b0;
        m1_bus_reqcyc = 1'b0; m1_bus_req = '0; m1_bus_reqtag = '0; m1_bus_respack = 1'b0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
        tick();
        do_reset();

        // Single m0 read.
        read_txn(1'b0, 64'h1000, 64'h100, BEATS);
        @(negedge clk);
        chk("rd_done_busy", 64'(busy), 64'd0);
        tick();

        // Both masters from reset; grants must alternate starting with m0.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_req(~k[0], 1'b1, 64'h3000 + 64'(k), rd_tag);
            read_txn(k[0], 64'h4000 + 64'(k), 64'h200 + 64'(16 * k), BEATS);
        end
        m0_bus_reqcyc = 1'b0;
        m1_bus_reqcyc = 1'b0;
        @(negedge clk);
        chk("alt_done_busy", 64'(busy), 64'd0);
        tick();
        @(negedge clk);
        chk("alt_no_regrant", 64'(busy), 64'd0);
        tick();

        // m1 write with two stall cycles before each accepted beat.
        set_req(1'b1, 1'b1, 64'h2000, wr_tag);
        @(negedge clk);
        chk("wr_idle_busy", 64'(busy), 64'd0);
        tick();
        bus_reqack = 1'b1;
        @(negedge clk);
        chk("wr_grant", 64'(grant), 64'd1);
        chk("wr_addr", bus_req, 64'h2000);
        chk("wr_tag", 64'(bus_reqtag), 64'(wr_tag));
        chk("wr_addr_ack", 64'(reqack_v), 64'd2);
        tick();
        bus_reqack = 1'b0;
        for (int i = 0; i < BEATS; i++) begin
            m1_bus_req = 64'hA0 + 64'(i);
            for (int s = 0; s < 2; s++) begin
                @(negedge clk);
                chk("wr_stall_ack", 64'(reqack_v), 64'd0);
                chk("wr_stall_data", bus_req, 64'hA0 + 64'(i));
                chk("wr_stall_busy", 64'(busy), 64'd1);
                tick();
            end
            bus_reqack = 1'b1;
            @(negedge clk);
            chk("wr_beat_ack", 64'(reqack_v), 64'd2);
            chk("wr_beat_cyc", 64'(bus_reqcyc), 64'd1);
            chk("wr_beat_data", bus_req, 64'hA0 + 64'(i));
            tick();
            bus_reqack = 1'b0;
        end
        m1_bus_reqcyc = 1'b0;
        @(negedge clk);
        chk("wr_done_busy", 64'(busy), 64'd0);
        chk("wr_done_cyc", 64'(bus_reqcyc), 64'd0);
        tick();

        // Stray response beat while idle must be dropped.
        bus_respcyc = 1'b1;
        bus_resp = 64'hDEAD;
        m0_bus_respack = 1'b1;
        m1_bus_respack = 1'b1;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk("stray_respcyc", 64'(respcyc_v), 64'd0);
            chk("stray_respack", 64'(bus_respack), 64'd0);
            chk("stray_busy", 64'(busy), 64'd0);
            tick();
        end
        bus_respcyc = 1'b0;

        // Reset after the third read beat, then m1 is served normally.
        read_txn(1'b0, 64'h5000, 64'h500, 3);
        bus_respcyc = 1'b1;
        bus_resp = 64'h503;
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_outs", 64'(any_out), 64'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_after_outs", 64'(any_out), 64'd0);
        chk("midrst_after_busy", 64'(busy), 64'd0);
        tick();
        bus_respcyc = 1'b0;
        read_txn(1'b1, 64'h6000, 64'h600, BEATS);

        // m0 aborts in the address phase; pending m1 is granted next.
        set_req(1'b0, 1'b1, 64'h7000, rd_tag);
        set_req(1'b1, 1'b1, 64'h8000, rd_tag);
        @(negedge clk);
        chk("abort_idle_busy", 64'(busy), 64'd0);
        tick();
        @(negedge clk);
        chk("abort_grant0", 64'(grant), 64'd0);
        chk("abort_req0", bus_req, 64'h7000);
        tick();
        m0_bus_reqcyc = 1'b0;
        @(negedge clk);
        chk("abort_drop_cyc", 64'(bus_reqcyc), 64'd0);
        tick();
        @(negedge clk);
        chk("abort_back_idle", 64'(busy), 64'd0);
        tick();
        @(negedge clk);
        chk("abort_grant1", 64'(grant), 64'd1);
        chk("abort_busy1", 64'(busy), 64'd1);
        chk("abort_req1", bus_req, 64'h8000);
        tick();
        m1_bus_reqcyc = 1'b0;
        @(negedge clk);
        chk("abort_m1_drop", 64'(bus_reqcyc), 64'd0);
        tick();
        @(negedge clk);
        chk("abort_final_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
